// File: rtl/cfar_peak_collector.sv
// CFAR peak collector: rising-edge detection capture into a FWFT FIFO with per-frame counting.
// Optional feature: define CFAR_PEAK_DEDUP_EN to drop repeats of the last accepted index in a frame.
module cfar_peak_collector #(
   parameter int unsigned INDEX_WIDTH = 10,
   parameter int unsigned DEPTH       = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     max_valid,
   input  logic [INDEX_WIDTH-1:0]   index_out,
   input  logic                     eop_in,
   input  logic                     peak_ready,
   output logic                     peak_valid,
   output logic [INDEX_WIDTH-1:0]   peak_index,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     frame_done,
   output logic [INDEX_WIDTH:0]     frame_count,
   output logic                     overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic                   mv_q, mv_d;
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [AW:0]            level_q, level_d;
   logic [INDEX_WIDTH:0]   cnt_q, cnt_d;
   logic [INDEX_WIDTH:0]   fcnt_q, fcnt_d;
   logic                   fdone_q, fdone_d;
   logic                   ovf_q, ovf_d;
   logic [INDEX_WIDTH-1:0] mem_q [DEPTH];

   logic capture, dup, take, full, push, pop;

`ifdef CFAR_PEAK_DEDUP_EN
   logic                   hist_vld_q, hist_vld_d;
   logic [INDEX_WIDTH-1:0] hist_q, hist_d;
`endif

   always_comb begin
      mv_d    = max_valid;
      capture = max_valid & ~mv_q;
`ifdef CFAR_PEAK_DEDUP_EN
      dup     = hist_vld_q & (hist_q == index_out);
`else
      dup     = 1'b0;
`endif
      take    = capture & ~dup;
      full    = (level_q == FULL_LEVEL);
      pop     = (level_q != '0) & peak_ready;
      // A full FIFO still accepts when the head leaves on the same edge.
      push    = take & (~full | pop);

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      level_d = level_q;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;

      ovf_d = ovf_q | (take & full & ~pop);

      cnt_d = cnt_q;
      if (take && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

`ifdef CFAR_PEAK_DEDUP_EN
      hist_d     = hist_q;
      hist_vld_d = hist_vld_q;
      if (push) begin
         hist_d     = index_out;
         hist_vld_d = 1'b1;
      end
`endif

      fdone_d = eop_in;
      fcnt_d  = fcnt_q;
      if (eop_in) begin
         fcnt_d = cnt_d;
         cnt_d  = '0;
`ifdef CFAR_PEAK_DEDUP_EN
         hist_vld_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mv_q     <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         cnt_q    <= '0;
         fcnt_q   <= '0;
         fdone_q  <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef CFAR_PEAK_DEDUP_EN
         hist_q     <= '0;
         hist_vld_q <= 1'b0;
`endif
      end else begin
         mv_q     <= mv_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         cnt_q    <= cnt_d;
         fcnt_q   <= fcnt_d;
         fdone_q  <= fdone_d;
         ovf_q    <= ovf_d;
`ifdef CFAR_PEAK_DEDUP_EN
         hist_q     <= hist_d;
         hist_vld_q <= hist_vld_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= index_out;
   end

   // Storage is not reset, so the head is masked to zero while empty.
   assign peak_valid  = (level_q != '0);
   assign peak_index  = peak_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_level  = level_q;
   assign frame_done  = fdone_q;
   assign frame_count = fcnt_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_cfar_peak_collector.sv
// Self-checking bench for cfar_peak_collector against a queue-based behavioural model.
module tb_cfar_peak_collector;

   localparam int IW   = 10;
   localparam int D    = 16;
   localparam int LW   = $clog2(D) + 1;
   localparam int CMAX = (1 << (IW + 1)) - 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          max_valid = 1'b0;
   logic [IW-1:0] index_out = '0;
   logic          eop_in = 1'b0;
   logic          peak_ready = 1'b0;
   logic          peak_valid;
   logic [IW-1:0] peak_index;
   logic [LW-1:0] fifo_level;
   logic          frame_done;
   logic [IW:0]   frame_count;
   logic          overflow;

   int total = 0;
   int bad   = 0;

   int mq[$];
   bit m_prev, m_fdone, m_ovf, m_hv;
   int m_cnt, m_fcnt, m_hist;

   cfar_peak_collector #(.INDEX_WIDTH(IW), .DEPTH(D)) dut (
      .clk(clk), .reset_n(reset_n), .max_valid(max_valid), .index_out(index_out),
      .eop_in(eop_in), .peak_ready(peak_ready), .peak_valid(peak_valid),
      .peak_index(peak_index), .fifo_level(fifo_level), .frame_done(frame_done),
      .frame_count(frame_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      mq.delete();
      m_prev = 0; m_fdone = 0; m_ovf = 0; m_hv = 0;
      m_cnt = 0; m_fcnt = 0; m_hist = 0;
   endtask

   function automatic logic [IW-1:0] exp_head();
      if (mq.size() == 0) return '0;
      return IW'(mq[0]);
   endfunction

   // Frame/FIFO rules applied at one clock edge: head leaves first, then the new capture joins.
   task automatic model_step(input bit mv, input int idx, input bit eop, input bit rdy);
      bit cap, dup;
      cap = mv && !m_prev;
      m_prev = mv;
      dup = 0;
`ifdef CFAR_PEAK_DEDUP_EN
      dup = m_hv && (m_hist == idx);
`endif
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (cap && !dup) begin
         if (mq.size() < D) begin
            mq.push_back(idx);
            m_hist = idx;
            m_hv = 1;
         end else m_ovf = 1;
         if (m_cnt < CMAX) m_cnt++;
      end
      m_fdone = eop;
      if (eop) begin
         m_fcnt = m_cnt;
         m_cnt = 0;
         m_hv = 0;
      end
   endtask

   task automatic drive_step(input bit mv, input int idx, input bit eop, input bit rdy);
      max_valid = mv; index_out = IW'(idx); eop_in = eop; peak_ready = rdy;
      model_step(mv, idx, eop, rdy);
      @(posedge clk); #1;
   endtask

   task automatic cycle(input bit mv, input int idx, input bit eop, input bit rdy);
      @(negedge clk);
      drive_step(mv, idx, eop, rdy);
   endtask

   task automatic pulse(input int idx, input bit rdy);
      cycle(1, idx, 0, rdy);
      cycle(0, 0, 0, rdy);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 0; max_valid = 0; index_out = '0; eop_in = 0; peak_ready = 0;
      model_reset();
      @(negedge clk);
      reset_n = 1;
   endtask

   task automatic test_reset();
      #12;
      total++; if (peak_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", peak_valid); end
      total++; if (peak_index !== '0) begin bad++; $display("FAIL reset_index: got %0d want 0", peak_index); end
      total++; if (fifo_level !== '0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", frame_done); end
      total++; if (frame_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", frame_count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
   endtask

   task automatic test_single();
      do_reset();
      cycle(1, 37, 0, 0);
      total++; if (peak_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b want 1", peak_valid); end
      total++; if (peak_index !== IW'(37)) begin bad++; $display("FAIL single_index: got %0d want 37", peak_index); end
      total++; if (fifo_level !== LW'(1)) begin bad++; $display("FAIL single_level: got %0d want 1", fifo_level); end
      cycle(0, 0, 0, 0);
   endtask

   task automatic test_held();
      do_reset();
      cycle(1, 100, 0, 0);
      cycle(1, 101, 0, 0);
      cycle(1, 102, 0, 0);
      cycle(0, 0, 0, 0);
      total++; if (fifo_level !== LW'(1)) begin bad++; $display("FAIL held_level: got %0d want 1", fifo_level); end
      total++; if (peak_index !== IW'(100)) begin bad++; $display("FAIL held_index: got %0d want 100", peak_index); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         pulse(i, 0);
         if (i == 15) begin
            total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %0b want 0", overflow); end
         end
      end
      total++; if (fifo_level !== LW'(D)) begin bad++; $display("FAIL ovf_level: got %0d want %0d", fifo_level, D); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
      for (int i = 0; i < 16; i++) begin
         total++; if (peak_index !== IW'(i)) begin bad++; $display("FAIL ovf_pop%0d: got %0d want %0d", i, peak_index, i); end
         cycle(0, 0, 0, 1);
      end
      total++; if (peak_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %0b want 0", peak_valid); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [IW-1:0] want;
      do_reset();
      for (int i = 0; i < 16; i++) pulse(i, 0);
      total++; if (fifo_level !== LW'(D)) begin bad++; $display("FAIL fpp_full: got %0d want %0d", fifo_level, D); end
      cycle(1, 500, 0, 1);
      total++; if (fifo_level !== LW'(D)) begin bad++; $display("FAIL fpp_level: got %0d want %0d", fifo_level, D); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf: got %0b want 0", overflow); end
      total++; if (peak_index !== IW'(1)) begin bad++; $display("FAIL fpp_head: got %0d want 1", peak_index); end
      cycle(0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         want = (i < 15) ? IW'(i + 1) : IW'(500);
         total++; if (peak_index !== want) begin bad++; $display("FAIL fpp_drain%0d: got %0d want %0d", i, peak_index, want); end
         cycle(0, 0, 0, 1);
      end
      total++; if (fifo_level !== '0) begin bad++; $display("FAIL fpp_drained: got %0d want 0", fifo_level); end
   endtask

   task automatic test_frame();
      do_reset();
      for (int i = 0; i < 4; i++) pulse(10 + i, 1);
      cycle(1, 14, 1, 1);
      total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL frame_done: got %0b want 1", frame_done); end
      total++; if (frame_count !== (IW+1)'(5)) begin bad++; $display("FAIL frame_count: got %0d want 5", frame_count); end
      cycle(0, 0, 0, 1);
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL frame_done_pulse: got %0b want 0", frame_done); end
      total++; if (frame_count !== (IW+1)'(5)) begin bad++; $display("FAIL frame_count_hold: got %0d want 5", frame_count); end
      pulse(7, 1);
      cycle(0, 0, 1, 1);
      total++; if (frame_count !== (IW+1)'(1)) begin bad++; $display("FAIL frame_next: got %0d want 1", frame_count); end
   endtask

   task automatic test_back_to_back();
      cycle(0, 0, 1, 1);
      cycle(0, 0, 1, 1);
      total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %0b want 1", frame_done); end
      total++; if (frame_count !== '0) begin bad++; $display("FAIL b2b_count: got %0d want 0", frame_count); end
   endtask

   task automatic test_dup();
      int want;
`ifdef CFAR_PEAK_DEDUP_EN
      want = 1;
`else
      want = 2;
`endif
      do_reset();
      pulse(200, 0);
      pulse(200, 0);
      cycle(0, 0, 1, 0);
      total++; if (fifo_level !== LW'(want)) begin bad++; $display("FAIL dup_level: got %0d want %0d", fifo_level, want); end
      total++; if (frame_count !== (IW+1)'(want)) begin bad++; $display("FAIL dup_count: got %0d want %0d", frame_count, want); end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      for (int i = 0; i < 3; i++) pulse(50 + i, 0);
      cycle(1, 300, 0, 0);
      #3;
      reset_n = 0;
      model_reset();
      #1;
      total++; if (peak_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %0b want 0", peak_valid); end
      total++; if (fifo_level !== '0) begin bad++; $display("FAIL mid_level: got %0d want 0", fifo_level); end
      total++; if (peak_index !== '0) begin bad++; $display("FAIL mid_index: got %0d want 0", peak_index); end
      @(negedge clk);
      reset_n = 1;
      drive_step(1, 301, 0, 0);
      total++; if (fifo_level !== LW'(1)) begin bad++; $display("FAIL mid_cap_level: got %0d want 1", fifo_level); end
      total++; if (peak_index !== IW'(301)) begin bad++; $display("FAIL mid_cap_index: got %0d want 301", peak_index); end
      cycle(0, 0, 1, 0);
      total++; if (frame_count !== (IW+1)'(1)) begin bad++; $display("FAIL mid_count: got %0d want 1", frame_count); end
   endtask

   task automatic test_random();
      bit mv, eop, rdy;
      int idx;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         mv  = ($urandom_range(0, 1) == 1);
         idx = $urandom_range(0, 1023);
         eop = ($urandom_range(0, 15) == 0);
         rdy = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
         cycle(mv, idx, eop, rdy);
         total++; if (peak_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid@%0d: got %0b want %0b", n, peak_valid, mq.size() != 0); end
         total++; if (peak_index !== exp_head()) begin bad++; $display("FAIL rnd_index@%0d: got %0d want %0d", n, peak_index, exp_head()); end
         total++; if (fifo_level !== LW'(mq.size())) begin bad++; $display("FAIL rnd_level@%0d: got %0d want %0d", n, fifo_level, mq.size()); end
         total++; if (frame_done !== m_fdone) begin bad++; $display("FAIL rnd_done@%0d: got %0b want %0b", n, frame_done, m_fdone); end
         total++; if (frame_count !== (IW+1)'(m_fcnt)) begin bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, frame_count, m_fcnt); end
         total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf@%0d: got %0b want %0b", n, overflow, m_ovf); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_held();
      test_overflow();
      test_full_push_pop();
      test_frame();
      test_back_to_back();
      test_dup();
      test_reset_midframe();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cfar_peak_collector.md
CFAR_PEAK_COLLECTOR -- requirements
Module: cfar_peak_collector

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 10, giving the detection index width (1024-cell range).
REQ-002 SHALL have parameter DEPTH, default 16, giving the peak FIFO entries; it is a power of two, at least 2.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port max_valid  input  1  detection strobe from the CFAR detector.
REQ-006 SHALL have port index_out  input  INDEX_WIDTH  detector cell index, sampled with max_valid.
REQ-007 SHALL have port eop_in  input  1  one-cycle marker of the last cell of a frame.
REQ-008 SHALL have port peak_ready  input  1  downstream accepts the head entry.
REQ-009 SHALL have port peak_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port peak_index  output  INDEX_WIDTH  head entry, first-word-fall-through.
REQ-011 SHALL have port fifo_level  output  $clog2(DEPTH)+1  entries held.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse, one cycle after eop_in.
REQ-013 SHALL have port frame_count  output  INDEX_WIDTH+1  detections captured in the last completed frame.
REQ-014 SHALL have port overflow  output  1  sticky flag: a detection was dropped.

Function
REQ-015 SHALL register max_valid each cycle; a capture occurs only when max_valid=1 and the registered value is 0, so a strobe held high for N cycles yields one capture.
REQ-016 SHALL take the captured value from index_out in the capture cycle.
REQ-017 SHALL write a capture at edge k so that peak_valid=1 and the entry is visible from edge k+1; latency is 1 cycle.
REQ-018 SHALL pop the head on any edge with peak_valid=1 and peak_ready=1.
REQ-019 SHALL ignore peak_ready while peak_valid=0.
REQ-020 SHALL hold peak_index stable while peak_valid=1 and peak_ready=0.
REQ-021 SHALL accept a capture when the FIFO is not full, or when it is full and a pop occurs in the same cycle; in that case fifo_level stays DEPTH.
REQ-022 SHALL drop a capture when the FIFO is full and no pop occurs, set overflow=1 from the next cycle, and leave FIFO contents unchanged.
REQ-023 SHALL change fifo_level by +1 on push only, -1 on pop only, and 0 on push+pop.
REQ-024 SHALL wrap the read and write pointers modulo DEPTH.
REQ-025 SHALL keep a per-frame detection counter that increments on each accepted capture and saturates at all-ones.
REQ-026 SHALL count dropped captures in the per-frame counter as well, so it reflects detector output.
REQ-027 SHALL, on eop_in=1, load frame_count with the counter value, including a capture in the same cycle, pulse frame_done on the next cycle, and clear the counter to 0.
REQ-028 SHALL, on back-to-back eop_in, report frame_count=0 for an empty frame.
REQ-029 SHALL keep overflow at 1 until reset.

Reset
REQ-030 SHALL, while reset_n=0, drive peak_valid=0, peak_index=0, fifo_level=0, frame_done=0, frame_count=0 and overflow=0.
REQ-031 SHALL, while reset_n=0, empty the FIFO, zero both pointers, clear the detection counter and clear the registered max_valid.
REQ-032 SHALL capture max_valid=1 in the first cycle after release, since the registered value is 0.
REQ-033 SHALL discard all in-flight state when reset is asserted mid-frame; there is no partial frame report.

Configuration
REQ-034 SHALL, with macro CFAR_PEAK_DEDUP_EN defined, discard a capture whose index equals the last accepted index of the current frame.
REQ-035 SHALL, with CFAR_PEAK_DEDUP_EN defined, neither push nor count a discarded capture, and clear the last-index history at eop_in and at reset.
REQ-036 SHALL, without CFAR_PEAK_DEDUP_EN defined, accept every rising-edge capture subject only to FIFO space.

Verification
REQ-037 SHALL verify: reset, then a 1-cycle max_valid with index_out=37 -> next cycle peak_valid=1, peak_index=37, fifo_level=1.
REQ-038 SHALL verify: max_valid held 3 cycles, index 100/101/102 -> exactly one entry, value 100.
REQ-039 SHALL verify: peak_ready=0 and 17 separate pulses, index 0..16 -> fifo_level=16, overflow=1, entries pop as 0..15.
REQ-040 SHALL verify: full FIFO, peak_ready=1 and a pulse with index 500 in the same cycle -> level stays 16, overflow=0, 500 is the last entry.
REQ-041 SHALL verify: 5 pulses in a frame, the 5th coincident with eop_in -> frame_done for 1 cycle, frame_count=5, next frame starts counting from 0.
REQ-042 SHALL verify: two pulses, both index 200, in one frame -> 1 entry and frame_count=1 with CFAR_PEAK_DEDUP_EN; 2 entries and frame_count=2 without it.
